// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold the iteration count bw itself (not just bw-1).
  function automatic int cnt_width(input int bw);
    return $clog2(bw + 1);
  endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
// Latency: purely combinational.
// Backpressure: not applicable.
module ripple_borrow_subtractor #(
  parameter int width = 5
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] diff,
  output logic             borrow_out
);

  // A bit generates a borrow when it is 0 and the subtrahend bit is 1;
  // it passes an incoming borrow through when the two bits are equal.
  logic [width-1:0] gen;
  logic [width-1:0] prop;
  logic [width:0]   borrow;

  assign gen       = ~a & b;
  assign prop      = ~(a ^ b);
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < width; i++) begin : g_cell
    assign borrow[i+1] = gen[i] | (prop[i] & borrow[i]);
  end

  assign diff       = a ^ b ^ borrow[width-1:0];
  assign borrow_out = borrow[width];

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock via shift-and-subtract.
// Latency: result registered bw edges after accept; divide-by-zero result registered on the accept edge.
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int bw = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bw-1:0] dividend,
  input  logic [bw-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bw-1:0] quotient,
  output logic [bw-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = cnt_width(bw);

  state_e          state_q, state_d;
  logic [bw:0]     r_q, r_d;
  logic [bw-1:0]   q_q, q_d;
  logic [bw-1:0]   d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [bw-1:0]   quot_q, quot_d;
  logic [bw-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;

  // One iteration: shift the next dividend bit into the partial remainder,
  // try subtracting the divisor, keep the difference only if it did not borrow.
  logic [bw:0]     s;
  logic [bw:0]     d_ext;
  logic [bw:0]     diff;
  logic            borrow;
  logic [bw:0]     r_next;
  logic [bw-1:0]   q_next;

  assign s      = {r_q[bw-1:0], q_q[bw-1]};
  assign d_ext  = {1'b0, d_q};
  assign r_next = borrow ? s : diff;
  assign q_next = {q_q[bw-2:0], ~borrow};

  // R stays below D after every iteration, so its top bit is always zero
  // and only the low bw bits feed the next shift.
  logic r_top_unused;
  assign r_top_unused = r_q[bw];

  ripple_borrow_subtractor #(
    .width(bw + 1)
  ) u_sub (
    .a         (s),
    .b         (d_ext),
    .diff      (diff),
    .borrow_out(borrow)
  );

  // Next-state logic: accept in IDLE, iterate in CALC, hold result in DONE.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = CW'(bw);
          end
        end
      end
      CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = q_next;
          rem_d   = r_next[bw-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at bw=4.
// Directed cases, exhaustive sweep and random traffic against an arithmetic reference.
// Exercises result backpressure, held requests and mid-calculation reset.
module tb_restoring_divider;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] dividend;
  logic [BW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BW-1:0] exp_q;
  logic [BW-1:0] exp_r;
  logic          exp_z;

  always #5 clk = ~clk;

  restoring_divider #(.bw(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference: plain integer division; divide-by-zero yields all ones and the dividend.
  task automatic model(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      exp_q = '1;
      exp_r = a;
      exp_z = 1'b1;
    end else begin
      exp_q = BW'(ai / bi);
      exp_r = BW'(ai % bi);
      exp_z = 1'b0;
    end
  endtask

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " ready_before_accept"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string tag);
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " remainder"}, remainder, exp_r);
    chk({tag, " div_by_zero"}, div_by_zero, exp_z);
    chk({tag, " in_ready_busy"}, in_ready, 0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid_after_consume"}, out_valid, 0);
    chk({tag, " in_ready_after_consume"}, in_ready, 1);
    chk({tag, " quotient_hold"}, quotient, exp_q);
  endtask

  task automatic xact(input logic [BW-1:0] a, input logic [BW-1:0] b, input int stall, input string name);
    string tag;
    tag = $sformatf("%s %0d/%0d", name, a, b);
    model(a, b);
    send(a, b, tag);
    wait_result((b == '0) ? 0 : BW, tag);
    check_result(tag);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " stall_valid"}, out_valid, 1);
      chk({tag, " stall_quotient"}, quotient, exp_q);
      chk({tag, " stall_remainder"}, remainder, exp_r);
      chk({tag, " stall_in_ready"}, in_ready, 0);
    end
    consume(tag);
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // Basic and directed edge cases.
    xact(4'd13, 4'd4, 0, "basic");
    xact(4'd15, 4'd1, 0, "div_by_one");
    xact(4'd0,  4'd7, 0, "zero_dividend");
    xact(4'd5,  4'd7, 0, "small_dividend");
    xact(4'd9,  4'd0, 0, "div_zero");
    xact(4'd8,  4'd3, 0, "after_div_zero");

    // Result backpressure for five cycles.
    xact(4'd14, 4'd3, 5, "backpressure");

    // A request held during CALC/DONE of another is only taken once back in IDLE.
    model(4'd12, 4'd5);
    send(4'd12, 4'd5, "held_first");
    in_valid = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    wait_result(BW, "held_first");
    check_result("held_first");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("held out_valid_after_consume", out_valid, 0);
    chk("held in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("held second_accepted", in_ready, 0);
    model(4'd7, 4'd2);
    wait_result(BW, "held_second");
    check_result("held_second");
    consume("held_second");

    // Reset during the second CALC cycle discards the request.
    send(4'd11, 4'd2, "mid_reset");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_reset in_ready", in_ready, 1);
    chk("mid_reset out_valid", out_valid, 0);
    chk("mid_reset quotient", quotient, 0);
    chk("mid_reset remainder", remainder, 0);
    chk("mid_reset div_by_zero", div_by_zero, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("mid_reset no_result", seen, 0);
    xact(4'd6, 4'd4, 0, "after_reset");

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        xact(BW'(a), BW'(b), 0, "sweep");
      end
    end

    // Random operands with random result backpressure.
    for (int i = 0; i < 40; i++) begin
      xact(BW'($urandom_range(0, 15)), BW'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
